// File: rtl/map_pkg.sv
// Shared constants, FSM state encoding and saturating arithmetic for the
// alpha-metric SRAM controller.
package map_pkg;

    localparam int DATA_W     = 16;
    localparam int NUM_STATES = 8;
    localparam int MAX_STEPS  = 9;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_WAIT,
        RD_CAP,
        OUT,
        DONE
    } state_e;

    // a - b clamped to the signed range of a w-bit word (w <= 32).
    function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] diff;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        diff = {a[31], a} - {b[31], b};
        hi   = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo   = -(33'sd1 <<< (w - 1));
        if (diff > hi) begin
            return hi[31:0];
        end else if (diff < lo) begin
            return lo[31:0];
        end
        return diff[31:0];
    endfunction

endpackage

// File: rtl/alpha_sram_ctrl_norm.sv
// alpha_norm: subtracts lane 0 from every lane with signed saturation.
// Only compiled when ALPHA_SRAM_CTRL_NORM_EN is defined.
`ifdef ALPHA_SRAM_CTRL_NORM_EN
module alpha_norm #(
    parameter int DATA_W = map_pkg::DATA_W
) (
    input  logic signed [DATA_W-1:0] din  [map_pkg::NUM_STATES],
    output logic signed [DATA_W-1:0] dout [map_pkg::NUM_STATES]
);
    import map_pkg::*;

    always_comb begin
        for (int i = 0; i < NUM_STATES; i++) begin
            dout[i] = DATA_W'(sat_sub(32'(din[i]), 32'(din[0]), DATA_W));
        end
    end

endmodule
`endif

// File: rtl/alpha_sram_ctrl.sv
// Stores forward alpha vectors in SRAM, then replays them in reverse step order.
// Define ALPHA_SRAM_CTRL_NORM_EN to normalise read-back vectors against state 0.
module alpha_sram_ctrl #(
    parameter int DATA_W    = map_pkg::DATA_W,
    parameter int ADDR_W    = 8,
    parameter int MAX_STEPS = map_pkg::MAX_STEPS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [3:0]               frame_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data0,
    input  logic signed [DATA_W-1:0] in_data1,
    input  logic signed [DATA_W-1:0] in_data2,
    input  logic signed [DATA_W-1:0] in_data3,
    input  logic signed [DATA_W-1:0] in_data4,
    input  logic signed [DATA_W-1:0] in_data5,
    input  logic signed [DATA_W-1:0] in_data6,
    input  logic signed [DATA_W-1:0] in_data7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data0,
    output logic signed [DATA_W-1:0] out_data1,
    output logic signed [DATA_W-1:0] out_data2,
    output logic signed [DATA_W-1:0] out_data3,
    output logic signed [DATA_W-1:0] out_data4,
    output logic signed [DATA_W-1:0] out_data5,
    output logic signed [DATA_W-1:0] out_data6,
    output logic signed [DATA_W-1:0] out_data7,
    output logic [3:0]               out_step,
    output logic                     sram_write_read,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic signed [DATA_W-1:0] sram_in_data0,
    output logic signed [DATA_W-1:0] sram_in_data1,
    output logic signed [DATA_W-1:0] sram_in_data2,
    output logic signed [DATA_W-1:0] sram_in_data3,
    output logic signed [DATA_W-1:0] sram_in_data4,
    output logic signed [DATA_W-1:0] sram_in_data5,
    output logic signed [DATA_W-1:0] sram_in_data6,
    output logic signed [DATA_W-1:0] sram_in_data7,
    input  logic signed [DATA_W-1:0] sram_out_data0,
    input  logic signed [DATA_W-1:0] sram_out_data1,
    input  logic signed [DATA_W-1:0] sram_out_data2,
    input  logic signed [DATA_W-1:0] sram_out_data3,
    input  logic signed [DATA_W-1:0] sram_out_data4,
    input  logic signed [DATA_W-1:0] sram_out_data5,
    input  logic signed [DATA_W-1:0] sram_out_data6,
    input  logic signed [DATA_W-1:0] sram_out_data7,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    import map_pkg::*;

    typedef logic signed [DATA_W-1:0] word_t;

    word_t       in_vec  [NUM_STATES];
    word_t       rd_vec  [NUM_STATES];
    word_t       cap_vec [NUM_STATES];
    word_t       wdata_q [NUM_STATES];
    word_t       odata_q [NUM_STATES];
    state_e      state_q, state_d;
    logic [3:0]  k_q, k_d, len_q, len_d;
    logic        last_q, last_d, we_q, we_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic        accept, legal;

    function automatic logic [ADDR_W-1:0] step_addr(input logic [3:0] k);
        return ADDR_W'({k, 3'b000});
    endfunction

    assign in_vec = '{in_data0, in_data1, in_data2, in_data3,
                      in_data4, in_data5, in_data6, in_data7};
    assign rd_vec = '{sram_out_data0, sram_out_data1, sram_out_data2, sram_out_data3,
                      sram_out_data4, sram_out_data5, sram_out_data6, sram_out_data7};

`ifdef ALPHA_SRAM_CTRL_NORM_EN
    alpha_norm #(.DATA_W(DATA_W)) u_norm (
        .din  (rd_vec),
        .dout (cap_vec)
    );
`else
    assign cap_vec = rd_vec;
`endif

    // last_q drops in_ready as soon as the final vector is taken.
    assign in_ready  = (state_q == WR) && !last_q;
    assign accept    = in_ready && in_valid;
    assign legal     = (frame_len != 4'd0) && (32'(frame_len) <= MAX_STEPS);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign out_step  = k_q;
    assign sram_write_read = we_q;
    assign sram_addr = addr_q;

    assign {out_data7, out_data6, out_data5, out_data4,
            out_data3, out_data2, out_data1, out_data0} =
           {odata_q[7], odata_q[6], odata_q[5], odata_q[4],
            odata_q[3], odata_q[2], odata_q[1], odata_q[0]};
    assign {sram_in_data7, sram_in_data6, sram_in_data5, sram_in_data4,
            sram_in_data3, sram_in_data2, sram_in_data1, sram_in_data0} =
           {wdata_q[7], wdata_q[6], wdata_q[5], wdata_q[4],
            wdata_q[3], wdata_q[2], wdata_q[1], wdata_q[0]};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        last_d  = last_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_d = WR;
                        k_d     = 4'd0;
                        len_d   = frame_len;
                        last_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR: begin
                // The final write cycle still runs in WR; reads start after it.
                if (last_q) begin
                    state_d = RD_ADDR;
                    last_d  = 1'b0;
                    addr_d  = step_addr(k_q);
                end else if (accept) begin
                    we_d   = 1'b1;
                    addr_d = step_addr(k_q);
                    if (k_q == len_q - 4'd1) begin
                        last_d = 1'b1;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: state_d = RD_CAP;
            RD_CAP:  state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    if (k_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_ADDR;
                        k_d     = k_q - 4'd1;
                        addr_d  = step_addr(k_q - 4'd1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= 4'd0;
            len_q   <= 4'd0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            for (int i = 0; i < NUM_STATES; i++) begin
                wdata_q[i] <= '0;
                odata_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
            last_q  <= last_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            for (int i = 0; i < NUM_STATES; i++) begin
                if (accept) wdata_q[i] <= in_vec[i];
                if (state_q == RD_CAP) odata_q[i] <= cap_vec[i];
            end
        end
    end

endmodule

// File: tb/tb_alpha_sram_ctrl.sv
// Self-checking bench for alpha_sram_ctrl: table of frames plus reset/stall sequences,
// with write and output scoreboards fed by an SRAM behavioural model.
module tb_alpha_sram_ctrl;
    localparam int DW = 16;
    localparam int AW = 8;

    typedef logic [8*DW-1:0] packed_t;
    typedef struct { logic [AW-1:0] addr; packed_t data; } wr_exp_t;
    typedef struct { logic [3:0] step; packed_t data; } out_exp_t;
    typedef struct { logic [3:0] len; int mode; bit expErr; bit stall; } frame_t;

    logic clk, rst, start, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] frame_len, out_step;
    logic sram_write_read, busy, done, err;
    logic [AW-1:0] sram_addr;
    logic signed [DW-1:0] in_data0, in_data1, in_data2, in_data3, in_data4, in_data5, in_data6, in_data7;
    logic signed [DW-1:0] out_data0, out_data1, out_data2, out_data3, out_data4, out_data5, out_data6, out_data7;
    logic signed [DW-1:0] sram_in_data0, sram_in_data1, sram_in_data2, sram_in_data3;
    logic signed [DW-1:0] sram_in_data4, sram_in_data5, sram_in_data6, sram_in_data7;
    packed_t rdPacked, wrPacked, outPacked;
    packed_t mem [256];

    wr_exp_t wq[$];
    out_exp_t oq[$];
    wr_exp_t wTmp;
    out_exp_t oTmp;
    frame_t tbl [8];
    packed_t vecs [9];
    int vectors = 0, miscompares = 0, doneCnt = 0, errCnt = 0;
    bit busySeen = 0;

    alpha_sram_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_data4(in_data4), .in_data5(in_data5), .in_data6(in_data6), .in_data7(in_data7),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
        .out_data4(out_data4), .out_data5(out_data5), .out_data6(out_data6), .out_data7(out_data7),
        .out_step(out_step), .sram_write_read(sram_write_read), .sram_addr(sram_addr),
        .sram_in_data0(sram_in_data0), .sram_in_data1(sram_in_data1),
        .sram_in_data2(sram_in_data2), .sram_in_data3(sram_in_data3),
        .sram_in_data4(sram_in_data4), .sram_in_data5(sram_in_data5),
        .sram_in_data6(sram_in_data6), .sram_in_data7(sram_in_data7),
        .sram_out_data0(rdPacked[0*DW +: DW]), .sram_out_data1(rdPacked[1*DW +: DW]),
        .sram_out_data2(rdPacked[2*DW +: DW]), .sram_out_data3(rdPacked[3*DW +: DW]),
        .sram_out_data4(rdPacked[4*DW +: DW]), .sram_out_data5(rdPacked[5*DW +: DW]),
        .sram_out_data6(rdPacked[6*DW +: DW]), .sram_out_data7(rdPacked[7*DW +: DW]),
        .busy(busy), .done(done), .err(err)
    );

    assign wrPacked  = {sram_in_data7, sram_in_data6, sram_in_data5, sram_in_data4,
                        sram_in_data3, sram_in_data2, sram_in_data1, sram_in_data0};
    assign outPacked = {out_data7, out_data6, out_data5, out_data4,
                        out_data3, out_data2, out_data1, out_data0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read SRAM: data for an address appears one edge later.
    always @(posedge clk) begin
        if (sram_write_read) mem[sram_addr] <= wrPacked;
        else rdPacked <= mem[sram_addr];
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (sram_write_read) begin
                if (wq.size() == 0) begin
                    checkOutput("unexpected_write", sram_addr, '1);
                end else begin
                    wTmp = wq.pop_front();
                    checkOutput("write_addr", sram_addr, wTmp.addr);
                    checkOutput("write_data", wrPacked, wTmp.data);
                end
            end
            if (out_valid && out_ready) begin
                if (oq.size() == 0) begin
                    checkOutput("unexpected_output", out_step, '1);
                end else begin
                    oTmp = oq.pop_front();
                    checkOutput("out_step", out_step, oTmp.step);
                    checkOutput("out_data", outPacked, oTmp.data);
                end
            end
            if (done) doneCnt++;
            if (err) errCnt++;
            if (busy) busySeen = 1;
        end
    end

    function automatic packed_t expOut(input packed_t v);
        packed_t r;
        int d;
        r = v;
`ifdef ALPHA_SRAM_CTRL_NORM_EN
        for (int i = 0; i < 8; i++) begin
            d = int'($signed(v[i*DW +: DW])) - int'($signed(v[0 +: DW]));
            if (d > 32767) d = 32767;
            if (d < -32768) d = -32768;
            r[i*DW +: DW] = 16'(d);
        end
`endif
        return r;
    endfunction

    task automatic driveVec(input packed_t v);
        {in_data7, in_data6, in_data5, in_data4, in_data3, in_data2, in_data1, in_data0} = v;
    endtask

    task automatic buildVecs(input int mode);
        for (int s = 0; s < 9; s++) begin
            for (int i = 0; i < 8; i++) begin
                if (mode == 1) vecs[s][i*DW +: DW] = 16'($urandom);
                else vecs[s][i*DW +: DW] = 16'(10 * (s + 1) + i);
            end
        end
        if (mode == 2) begin
            vecs[0] = {16'd21, 16'd18, 16'd15, 16'd12, 16'hFFFB, 16'h7FFF, 16'h8000, 16'd100};
        end
    endtask

    task automatic sendVecs(input int count, input int len, input int mode, output bit ok);
        int guard;
        ok = 1;
        for (int s = 0; s < count; s++) begin
            if (mode == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            driveVec(vecs[s]);
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
            if (!in_ready) begin
                checkOutput("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                ok = 0;
                return;
            end
            wq.push_back('{addr: AW'(s * 8), data: vecs[s]});
            if (s == len - 1) begin
                for (int t = len - 1; t >= 0; t--) oq.push_back('{step: 4'(t), data: expOut(vecs[t])});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic stallSequence(input logic [3:0] len);
        int guard = 0;
        logic [3:0] snapStep;
        packed_t snapData;
        logic [AW-1:0] snapAddr;
        while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
        checkOutput("stall_valid_seen", out_valid, 1);
        snapStep = out_step;
        snapData = outPacked;
        snapAddr = sram_addr;
        checkOutput("stall_first_step", snapStep, len - 4'd1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_step", out_step, snapStep);
            checkOutput("stall_data", outPacked, snapData);
            checkOutput("stall_addr", sram_addr, snapAddr);
            checkOutput("stall_no_write", sram_write_read, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        guard = 0;
        while (!out_valid && guard < 10) begin @(posedge clk); #1; guard++; end
        checkOutput("next_vector_latency", guard, 3);
    endtask

    task automatic applyStimulus(input frame_t f);
        int errBefore, doneBefore, guard;
        bit ok;
        errBefore = errCnt;
        doneBefore = doneCnt;
        buildVecs(f.mode);
        if (f.expErr) busySeen = 0;
        if (f.stall) out_ready = 1'b0;
        start = 1'b1;
        frame_len = f.len;
        @(posedge clk); #1;
        start = 1'b0;
        if (f.expErr) begin
            repeat (3) begin @(posedge clk); #1; end
            checkOutput("err_pulse_count", errCnt - errBefore, 1);
            checkOutput("err_busy", busySeen, 0);
            return;
        end
        sendVecs(f.len, f.len, f.mode, ok);
        if (!ok) return;
        if (f.stall) stallSequence(f.len);
        guard = 0;
        while (doneCnt == doneBefore && guard < 400) begin @(negedge clk); guard++; end
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("done_once", doneCnt - doneBefore, 1);
        checkOutput("err_quiet", errCnt - errBefore, 0);
        checkOutput("writes_drained", wq.size(), 0);
        checkOutput("outputs_drained", oq.size(), 0);
        checkOutput("idle_after_done", busy, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_busy_done_err"}, {busy, done, err}, 0);
        checkOutput({tag, "_sram_we"}, sram_write_read, 0);
        checkOutput({tag, "_sram_addr"}, sram_addr, 0);
        checkOutput({tag, "_out_step"}, out_step, 0);
        checkOutput({tag, "_out_data"}, outPacked, 0);
        checkOutput({tag, "_sram_in_data"}, wrPacked, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        frame_t rf;
        bit ok;
        tbl[0] = '{len: 4'd3,  mode: 0, expErr: 1'b0, stall: 1'b0};
        tbl[1] = '{len: 4'd0,  mode: 0, expErr: 1'b1, stall: 1'b0};
        tbl[2] = '{len: 4'd10, mode: 0, expErr: 1'b1, stall: 1'b0};
        tbl[3] = '{len: 4'd9,  mode: 1, expErr: 1'b0, stall: 1'b0};
        tbl[4] = '{len: 4'd2,  mode: 0, expErr: 1'b0, stall: 1'b1};
        tbl[5] = '{len: 4'd1,  mode: 2, expErr: 1'b0, stall: 1'b0};
        tbl[6] = '{len: 4'd15, mode: 0, expErr: 1'b1, stall: 1'b0};
        tbl[7] = '{len: 4'd5,  mode: 1, expErr: 1'b0, stall: 1'b0};

        rst = 1'b0;
        start = 1'b0;
        frame_len = 4'd0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        driveVec('0);
        repeat (3) begin @(posedge clk); #1; end
        checkResetOutputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 8; n++) begin
            $display("[TB] frame %0d: len=%0d mode=%0d", n, tbl[n].len, tbl[n].mode);
            applyStimulus(tbl[n]);
        end

        // Reset while in WR after two vectors have been accepted.
        buildVecs(0);
        start = 1'b1;
        frame_len = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        sendVecs(2, 4, 0, ok);
        #1;
        rst = 1'b0;
        #1;
        checkResetOutputs("midframe_reset");
        @(negedge clk);
        checkOutput("reset_no_write", sram_write_read, 0);
        wq.delete();
        oq.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rf = '{len: 4'd4, mode: 1, expErr: 1'b0, stall: 1'b0};
        applyStimulus(rf);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alpha_sram_ctrl.md
ALPHA_SRAM_CTRL -- requirements
Module: alpha_sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, width of one state metric (signed).
REQ-002 Parameter ADDR_W, default 8, width of SRAM word address.
REQ-003 Parameter MAX_STEPS, default 9, trellis steps held in SRAM (8 words per step, 72 words).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 start  in  1  one-cycle pulse, begins a frame; sampled only in IDLE.
REQ-007 frame_len  in  4  steps in frame, legal 1..MAX_STEPS, sampled with start.
REQ-008 in_valid / in_ready  in / out  1 each  forward-recursion alpha vector handshake.
REQ-009 in_data0..in_data7  in  DATA_W each  alpha vector, state 0..7.
REQ-010 out_valid / out_ready  out / in  1 each  reverse-order alpha vector handshake to LLR stage.
REQ-011 out_data0..out_data7  out  DATA_W each  alpha vector read back; out_step  out  4  step index of out_data.
REQ-012 sram_write_read  out  1  1 = write, 0 = read, to alpha SRAM.
REQ-013 sram_addr  out  ADDR_W  base word address (step*8); sram_in_data0..7  out  DATA_W each  write data.
REQ-014 sram_out_data0..7  in  DATA_W each  SRAM registered read data, valid one edge after address.
REQ-015 busy  out  1  high outside IDLE; done  out  1  one-cycle pulse at frame end; err  out  1  one-cycle pulse on illegal frame_len.

Function
REQ-016 States: IDLE, WR, RD_ADDR, RD_WAIT, RD_CAP, OUT, DONE.
REQ-017 IDLE: in_ready=0, sram_write_read=0; start with legal frame_len -> WR, step counter k=0; illegal (0 or >MAX_STEPS) -> err pulse, stay IDLE.
REQ-018 WR: in_ready=1; on in_valid&in_ready, next cycle drives sram_write_read=1 for exactly one cycle, sram_addr=k*8, sram_in_data=captured vector; k increments.
REQ-019 After write of step frame_len-1 -> RD_ADDR with k=frame_len-1; in_ready=0 from that acceptance edge on.
REQ-020 RD_ADDR: sram_write_read=0, sram_addr=k*8 -> RD_WAIT -> RD_CAP (captures sram_out_data into out_data) -> OUT.
REQ-021 OUT: out_valid=1, out_data and out_step=k stable until out_ready; on handshake, k=0 -> DONE, else k-1 -> RD_ADDR.
REQ-022 Read order strictly descending k = frame_len-1 .. 0; no write issued in any read state.
REQ-023 DONE: done=1 for one cycle -> IDLE.
REQ-024 start outside IDLE ignored; in_valid outside WR ignored, no SRAM write.
REQ-025 Latency: out_valid rises 3 cycles after entering RD_ADDR; next vector 3 cycles after handshake.
REQ-026 sram_addr never exceeds (MAX_STEPS-1)*8.

Reset
REQ-027 rst low: state IDLE, k=0, in_ready=0, out_valid=0, out_data*=0, out_step=0, sram_write_read=0, sram_addr=0, sram_in_data*=0, busy=0, done=0, err=0.
REQ-028 Reset mid-frame abandons frame immediately; sram_write_read is 0 throughout reset; SRAM contents undefined afterwards.

Configuration
REQ-029 Macro ALPHA_SRAM_CTRL_NORM_EN defined: RD_CAP stores each word minus sram_out_data0, signed saturating to DATA_W, so out_data0=0.
REQ-030 Macro undefined: RD_CAP stores sram_out_data unchanged; no subtractor built.

Structure
REQ-031 Shared package map_pkg holds DATA_W, NUM_STATES=8, MAX_STEPS, state enum, and saturating-subtract function.
REQ-032 One sub-module natural: alpha_norm (8-lane saturating subtract), instantiated only under ALPHA_SRAM_CTRL_NORM_EN.

Verification
REQ-033 frame_len=3, vectors {10..17},{20..27},{30..37}, out_ready=1 -> writes at addr 0,8,16; outputs step2,1,0 with data 30..37,20..27,10..17; done once.
REQ-034 frame_len=0 and frame_len=10 -> err one cycle each, busy stays 0, no SRAM write.
REQ-035 out_ready held 0 for 5 cycles in OUT -> out_data and out_step unchanged, no new SRAM address issued.
REQ-036 rst low during WR after 2 accepted vectors -> all outputs at reset values same cycle; new start runs full frame correctly.
REQ-037 NORM_EN, stored vector {100,-32768,...} with word0=100 -> out_data0=0, out_data1=-32768 (saturated).
REQ-038 frame_len=9, in_valid with random gaps -> last write at addr 64, 9 outputs in order 8..0.
